// File: rtl/mem_access.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_access : RV32 MEM stage - bus access, load alignment/extension, stall.
// Rev 1.0
// ============================================================================
module mem_access #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_addr,
    input  logic [3:0]  EX_MEM_rden,
    input  logic        EX_MEM_rden_SEXT,
    input  logic [3:0]  EX_MEM_wren,
    input  logic [31:0] EX_MEM_wrdata,
    input  logic [4:0]  EX_rd,
    input  logic        EX_rd_vld,
    input  logic [31:0] EX_x_rd,
    output logic [4:0]  MEM_rd,
    output logic        MEM_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic        MEM_stall,
    output logic        MEM_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [29:0]   waddr_q, waddr_d;
    logic [3:0]    lanes_q, lanes_d;
    logic          we_q, we_d;
    logic          sext_q, sext_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic          rd_vld_q, rd_vld_d;

    logic [4:0]    mem_rd_q, mem_rd_d;
    logic          mem_rd_vld_q, mem_rd_vld_d;
    logic [31:0]   mem_x_rd_q, mem_x_rd_d;
    logic          mem_err_q, mem_err_d;

    logic          w_rd_any, w_wr_any, w_mem_op, w_legal, w_tmo;
    logic [3:0]    w_mask;
    logic [31:0]   w_ld_val;
    logic          w_unused;

    // Byte offset within the word is carried by the lane mask, not the address.
    assign w_unused = ^EX_MEM_addr[1:0];

    function automatic logic lane_ok(input logic [3:0] m);
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: lane_ok = 1'b1;
            default:                   lane_ok = 1'b0;
        endcase
    endfunction

    assign w_rd_any = |EX_MEM_rden;
    assign w_wr_any = |EX_MEM_wren;
    assign w_mem_op = w_rd_any | w_wr_any;
    assign w_mask   = EX_MEM_rden | EX_MEM_wren;
    assign w_legal  = !(w_rd_any && w_wr_any) && lane_ok(w_mask);
    assign w_tmo    = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        w_ld_val = dbus_rdata;
        case (lanes_q)
            4'b0001: w_ld_val = {{24{sext_q & dbus_rdata[7]}},  dbus_rdata[7:0]};
            4'b0010: w_ld_val = {{24{sext_q & dbus_rdata[15]}}, dbus_rdata[15:8]};
            4'b0100: w_ld_val = {{24{sext_q & dbus_rdata[23]}}, dbus_rdata[23:16]};
            4'b1000: w_ld_val = {{24{sext_q & dbus_rdata[31]}}, dbus_rdata[31:24]};
            4'b0011: w_ld_val = {{16{sext_q & dbus_rdata[15]}}, dbus_rdata[15:0]};
            4'b1100: w_ld_val = {{16{sext_q & dbus_rdata[31]}}, dbus_rdata[31:16]};
            default: w_ld_val = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        waddr_d      = waddr_q;
        lanes_d      = lanes_q;
        we_d         = we_q;
        sext_d       = sext_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        rd_vld_d     = rd_vld_q;
        mem_rd_d     = mem_rd_q;
        mem_rd_vld_d = mem_rd_vld_q;
        mem_x_rd_d   = mem_x_rd_q;
        mem_err_d    = 1'b0;
        MEM_stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!w_mem_op) begin
                    mem_rd_d     = EX_rd;
                    mem_rd_vld_d = EX_rd_vld;
                    mem_x_rd_d   = EX_x_rd;
                end else if (w_legal) begin
                    waddr_d      = EX_MEM_addr[31:2];
                    lanes_d      = w_mask;
                    we_d         = w_wr_any;
                    sext_d       = EX_MEM_rden_SEXT;
                    wdata_d      = EX_MEM_wrdata;
                    rd_d         = EX_rd;
                    rd_vld_d     = EX_rd_vld;
                    mem_rd_vld_d = 1'b0;
                    cnt_d        = '0;
                    MEM_stall    = 1'b1;
                    state_d      = S_REQ;
                end else begin
                    mem_err_d    = 1'b1;
                    mem_rd_vld_d = 1'b0;
                end
            end
            S_REQ: begin
                if (dbus_gnt) begin
                    if (we_q) begin
                        mem_rd_vld_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        // A same-cycle rvalid is ignored; data is taken only in WAIT_R.
                        cnt_d     = '0;
                        MEM_stall = 1'b1;
                        state_d   = S_WAIT_R;
                    end
                end else if (w_tmo) begin
                    mem_err_d    = 1'b1;
                    mem_rd_vld_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    MEM_stall = 1'b1;
                end
            end
            S_WAIT_R: begin
                if (dbus_rvalid) begin
                    mem_x_rd_d   = w_ld_val;
                    mem_rd_d     = rd_q;
                    mem_rd_vld_d = rd_vld_q;
                    state_d      = S_IDLE;
                end else if (w_tmo) begin
                    mem_err_d    = 1'b1;
                    mem_rd_vld_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    MEM_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            waddr_q      <= '0;
            lanes_q      <= '0;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            wdata_q      <= '0;
            rd_q         <= '0;
            rd_vld_q     <= 1'b0;
            mem_rd_q     <= '0;
            mem_rd_vld_q <= 1'b0;
            mem_x_rd_q   <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            waddr_q      <= waddr_d;
            lanes_q      <= lanes_d;
            we_q         <= we_d;
            sext_q       <= sext_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            rd_vld_q     <= rd_vld_d;
            mem_rd_q     <= mem_rd_d;
            mem_rd_vld_q <= mem_rd_vld_d;
            mem_x_rd_q   <= mem_x_rd_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign MEM_rd     = mem_rd_q;
    assign MEM_rd_vld = mem_rd_vld_q;
    assign MEM_x_rd   = mem_x_rd_q;
    assign MEM_err    = mem_err_q;

    // Bus fields are only driven while a request is presented.
    assign dbus_req   = (state_q == S_REQ);
    assign dbus_we    = dbus_req & we_q;
    assign dbus_be    = dbus_req ? lanes_q : 4'b0000;
    assign dbus_addr  = dbus_req ? {waddr_q, 2'b00} : 32'h0;
    assign dbus_wdata = dbus_req ? wdata_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_access : directed bench for mem_access with a transaction-level model.
// Rev 1.0
// ============================================================================
module tb_mem_access;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_MEM_addr, EX_MEM_wrdata, EX_x_rd;
    logic [3:0]  EX_MEM_rden, EX_MEM_wren;
    logic        EX_MEM_rden_SEXT, EX_rd_vld;
    logic [4:0]  EX_rd;
    logic [4:0]  MEM_rd;
    logic        MEM_rd_vld, MEM_stall, MEM_err;
    logic [31:0] MEM_x_rd;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_addr(EX_MEM_addr), .EX_MEM_rden(EX_MEM_rden),
        .EX_MEM_rden_SEXT(EX_MEM_rden_SEXT), .EX_MEM_wren(EX_MEM_wren),
        .EX_MEM_wrdata(EX_MEM_wrdata), .EX_rd(EX_rd), .EX_rd_vld(EX_rd_vld),
        .EX_x_rd(EX_x_rd), .MEM_rd(MEM_rd), .MEM_rd_vld(MEM_rd_vld),
        .MEM_x_rd(MEM_x_rd), .MEM_stall(MEM_stall), .MEM_err(MEM_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Expected values: e_* hold for the current cycle, n_* become current after the edge.
    logic        chk_en = 1'b0, in_rst = 1'b1;
    logic [4:0]  e_rd, n_rd;
    logic        e_vld, n_vld, e_err, n_err;
    logic [31:0] e_x, n_x;
    logic        e_stall, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic [31:0] last_addr = 32'h0;
    int          reqcyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dbus_req) last_addr = dbus_addr;
        if (chk_en) begin
            if (!in_rst) begin
                chk("stall", {31'b0, MEM_stall}, {31'b0, e_stall});
                chk("req",   {31'b0, dbus_req},  {31'b0, e_req});
                chk("we",    {31'b0, dbus_we},   {31'b0, e_we});
                chk("be",    {28'b0, dbus_be},   {28'b0, e_be});
                chk("addr",  dbus_addr,  e_addr);
                chk("wdata", dbus_wdata, e_wdata);
            end
            chk("rd",     {27'b0, MEM_rd},     {27'b0, e_rd});
            chk("rd_vld", {31'b0, MEM_rd_vld}, {31'b0, e_vld});
            chk("x_rd",   MEM_x_rd, e_x);
            chk("err",    {31'b0, MEM_err},    {31'b0, e_err});
        end
    end

    // Load result: shift the addressed lanes down, then zero- or sign-extend by size.
    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [3:0] m,
                                             input logic s);
        int off = 0;
        int n = $countones(m);
        logic [31:0] v, keep;
        for (int i = 3; i >= 0; i--) if (m[i]) off = i;
        v = w >> (8 * off);
        if (n < 4) begin
            keep = (32'h1 << (8 * n)) - 32'h1;
            v = v & keep;
            if (s && v[8*n-1]) v = v | ~keep;
        end
        return v;
    endfunction

    function automatic logic legal_model(input logic [3:0] r, input logic [3:0] w);
        logic [3:0] m = r | w;
        if ((r != 0) && (w != 0)) return 1'b0;
        return (m == 4'b1111) || (m == 4'b0011) || (m == 4'b1100) || ($countones(m) == 1);
    endfunction

    task automatic comb_exp(input logic st, input logic rq, input logic we,
                            input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        e_stall = st; e_req = rq; e_we = we; e_be = be; e_addr = a; e_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        e_rd = n_rd; e_vld = n_vld; e_x = n_x; e_err = n_err;
    endtask

    task automatic bus_idle();
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic v, input logic [31:0] x);
        EX_MEM_rden = 4'b0; EX_MEM_wren = 4'b0; EX_MEM_rden_SEXT = 1'b0;
        EX_MEM_addr = 32'h0; EX_MEM_wrdata = 32'h0;
        EX_rd = rd; EX_rd_vld = v; EX_x_rd = x;
        bus_idle();
        comb_exp(0, 0, 0, 4'b0, 32'h0, 32'h0);
        n_rd = rd; n_vld = v; n_x = x; n_err = 0;
        tick();
    endtask

    // gdly/rdly: bus cycles spent waiting before gnt/rvalid (>= TO means never).
    task automatic mem(input logic [31:0] addr, input logic [3:0] rden, input logic [3:0] wren,
                       input logic sext, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rdv, input int gdly, input int rdly, input logic [31:0] rdata,
                       input logic both, input logic rst_in_wait, output int nreq);
        logic        store = (wren != 0);
        logic [3:0]  be = rden | wren;
        logic [31:0] a = {addr[31:2], 2'b00};
        logic        fin = 1'b0;
        nreq = 0;
        EX_MEM_addr = addr; EX_MEM_rden = rden; EX_MEM_wren = wren;
        EX_MEM_rden_SEXT = sext; EX_MEM_wrdata = wd;
        EX_rd = rd; EX_rd_vld = rdv; EX_x_rd = 32'h5555AAAA;
        bus_idle();
        n_rd = e_rd; n_x = e_x; n_vld = 0;
        if (!legal_model(rden, wren)) begin
            comb_exp(0, 0, 0, 4'b0, 32'h0, 32'h0);
            n_err = 1;
            tick();
            return;
        end
        comb_exp(1, 0, 0, 4'b0, 32'h0, 32'h0);
        n_err = 0;
        tick();
        for (int k = 0; k < TO; k++) begin
            nreq++;
            dbus_gnt = (k == gdly);
            dbus_rvalid = (k == gdly) && both;
            dbus_rdata = both ? 32'hA5A5A5A5 : 32'h0;
            if (k == gdly) begin
                comb_exp(!store, 1, store, be, a, wd);
                n_err = 0;
                fin = store;
                tick();
                break;
            end else if (k == TO - 1) begin
                comb_exp(0, 1, store, be, a, wd);
                n_err = 1;
                fin = 1'b1;
                tick();
            end else begin
                comb_exp(1, 1, store, be, a, wd);
                n_err = 0;
                tick();
            end
        end
        bus_idle();
        if (fin) return;
        for (int j = 0; j < TO; j++) begin
            dbus_rvalid = (j == rdly);
            dbus_rdata = (j == rdly) ? rdata : 32'h13579BDF;
            if (rst_in_wait) begin
                dbus_rvalid = 1'b0;
                comb_exp(1, 0, 0, 4'b0, 32'h0, 32'h0);
                rst = 1'b1; in_rst = 1'b1;
                n_rd = 0; n_vld = 0; n_x = 0; n_err = 0;
                tick();
                rst = 1'b0; in_rst = 1'b0;
                EX_MEM_addr = 0; EX_MEM_rden = 0; EX_MEM_wren = 0; EX_MEM_rden_SEXT = 0;
                EX_MEM_wrdata = 0; EX_rd = 0; EX_rd_vld = 0; EX_x_rd = 0;
                dbus_rvalid = 1'b1; dbus_rdata = 32'hDEADBEEF;
                comb_exp(0, 0, 0, 4'b0, 32'h0, 32'h0);
                tick();
                break;
            end else if (j == rdly) begin
                comb_exp(0, 0, 0, 4'b0, 32'h0, 32'h0);
                n_x = ld_model(rdata, rden, sext); n_rd = rd; n_vld = rdv; n_err = 0;
                tick();
                break;
            end else if (j == TO - 1) begin
                comb_exp(0, 0, 0, 4'b0, 32'h0, 32'h0);
                n_err = 1;
                tick();
            end else begin
                comb_exp(1, 0, 0, 4'b0, 32'h0, 32'h0);
                n_err = 0;
                tick();
            end
        end
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        EX_MEM_addr = 0; EX_MEM_rden = 0; EX_MEM_wren = 0; EX_MEM_rden_SEXT = 0;
        EX_MEM_wrdata = 0; EX_rd = 0; EX_rd_vld = 0; EX_x_rd = 0;
        bus_idle();
        comb_exp(0, 0, 0, 4'b0, 32'h0, 32'h0);
        n_rd = 0; n_vld = 0; n_x = 0; n_err = 0;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0; in_rst = 1'b0;

        // ALU pass-through
        alu(5'd5, 1'b1, 32'h1234);
        #1;
        chk("lit_alu_x",   MEM_x_rd, 32'h1234);
        chk("lit_alu_vld", {31'b0, MEM_rd_vld}, 32'h1);
        chk("lit_alu_rd",  {27'b0, MEM_rd}, 32'h5);

        // LB sign/zero extended; second pass also raises rvalid with gnt
        mem(32'h1003, 4'b1000, 4'b0, 1'b1, 32'h0, 5'd7, 1'b1, 0, 0, 32'h80FFFFFF, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_lb_x",    MEM_x_rd, 32'hFFFFFF80);
        chk("lit_lb_addr", last_addr, 32'h1000);
        mem(32'h1003, 4'b1000, 4'b0, 1'b0, 32'h0, 5'd7, 1'b1, 0, 0, 32'h80FFFFFF, 1'b1, 1'b0, reqcyc);
        #1;
        chk("lit_lbu_x",   MEM_x_rd, 32'h00000080);

        // SH with grant on the third request cycle
        mem(32'h2002, 4'b0, 4'b1100, 1'b0, 32'hBEEFBEEF, 5'd0, 1'b0, 2, 0, 32'h0, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_sh_reqcyc", reqcyc, 32'd3);
        chk("lit_sh_addr",   last_addr, 32'h2000);
        chk("lit_sh_vld",    {31'b0, MEM_rd_vld}, 32'h0);
        alu(5'd9, 1'b1, 32'hCAFEF00D);

        // Other lane/extension patterns
        mem(32'h4002, 4'b1100, 4'b0, 1'b1, 32'h0, 5'd3, 1'b1, 1, 2, 32'h80011234, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_lh_x", MEM_x_rd, 32'hFFFF8001);
        mem(32'h4001, 4'b0010, 4'b0, 1'b0, 32'h0, 5'd4, 1'b1, 0, 1, 32'h0000F000, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_lbu1_x", MEM_x_rd, 32'h000000F0);
        mem(32'h4000, 4'b0011, 4'b0, 1'b1, 32'h0, 5'd6, 1'b1, 0, 0, 32'hFFFF7ABC, 1'b0, 1'b0, reqcyc);
        mem(32'h5004, 4'b1111, 4'b0, 1'b1, 32'h0, 5'd8, 1'b1, 3, 0, 32'h89ABCDEF, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_lw_x", MEM_x_rd, 32'h89ABCDEF);
        mem(32'h6000, 4'b0, 4'b0001, 1'b0, 32'h11111111, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, reqcyc);

        // Grant timeout, then rvalid timeout
        mem(32'h3000, 4'b1111, 4'b0, 1'b0, 32'h0, 5'd10, 1'b1, 100, 0, 32'h0, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_to_reqcyc", reqcyc, 32'd8);
        chk("lit_to_err",    {31'b0, MEM_err}, 32'h1);
        chk("lit_to_vld",    {31'b0, MEM_rd_vld}, 32'h0);
        alu(5'd11, 1'b1, 32'h0BADF00D);
        mem(32'h3004, 4'b0100, 4'b0, 1'b1, 32'h0, 5'd12, 1'b1, 0, 100, 32'h0, 1'b0, 1'b0, reqcyc);
        alu(5'd13, 1'b0, 32'h77);

        // Reset while waiting for read data
        mem(32'h7000, 4'b1111, 4'b0, 1'b0, 32'h0, 5'd14, 1'b1, 0, 5, 32'h0, 1'b0, 1'b1, reqcyc);
        #1;
        chk("lit_rst_x",   MEM_x_rd, 32'h0);
        chk("lit_rst_vld", {31'b0, MEM_rd_vld}, 32'h0);
        alu(5'd15, 1'b1, 32'h42);

        // Illegal lane masks
        mem(32'h8000, 4'b0101, 4'b0, 1'b0, 32'h0, 5'd16, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0, reqcyc);
        #1;
        chk("lit_ill_err", {31'b0, MEM_err}, 32'h1);
        chk("lit_ill_vld", {31'b0, MEM_rd_vld}, 32'h0);
        mem(32'h8000, 4'b0001, 4'b0001, 1'b0, 32'h0, 5'd17, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0, reqcyc);
        mem(32'h8000, 4'b0110, 4'b0, 1'b0, 32'h0, 5'd18, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0, reqcyc);
        alu(5'd19, 1'b1, 32'h99);
        alu(5'd0, 1'b0, 32'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
